// File: rtl/msrh_lsu_pkg.sv
// Shared LSU definitions for the store-queue entry.
// Holds the store-queue entry state encoding, the replay counter sizing and the
// address bit below which a store-to-load forward is considered a doubleword match.
package msrh_lsu_pkg;

    // Replay counter width; the replay limit must fit in this many bits.
    localparam int STQ_REPLAY_W   = 4;
    localparam int STQ_MAX_REPLAY = 15;

    // Forwarding compares physical addresses at doubleword granularity.
    localparam int STQ_FWD_LSB = 3;

    typedef enum logic [3:0] {
        INIT       = 4'd0,
        TLB_HAZ    = 4'd1,
        WAIT_DATA  = 4'd2,
        READY      = 4'd3,
        DONE       = 4'd4,
        COMMIT     = 4'd5,
        L1D_CHECK  = 4'd6,
        WAIT_LRQ   = 4'd7,
        L1D_UPDATE = 4'd8
    } stq_state_t;

    // Saturating increment used for the replay counter.
    function automatic logic [STQ_REPLAY_W-1:0] replay_sat_inc(
        input logic [STQ_REPLAY_W-1:0] cnt,
        input logic [STQ_REPLAY_W-1:0] max_cnt
    );
        return (cnt >= max_cnt) ? max_cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/msrh_stq_entry_mp_if.sv
// Bus bundle between a store-queue entry and its surrounding LSU logic.
// slave  : the entry (consumes dispatch/ex1/commit/L1D events, drives the entry view)
// master : the LSU side (drives events, observes the entry view and forward hits)
interface msrh_stq_entry_mp_if
    import msrh_lsu_pkg::*;
#(
    parameter int LSU_INST_NUM = 2,
    parameter int DATA_W       = 64,
    parameter int PADDR_W      = 56,
    parameter int RNID_W       = 7,
    parameter int WAKE_NUM     = 4,
    parameter int CMT_ID_W     = 6,
    parameter int GRP_W        = 4,
    parameter int LRQ_SIZE     = 8
) ();

    logic                         i_disp_load;
    logic [CMT_ID_W-1:0]          i_disp_cmt_id;
    logic [GRP_W-1:0]             i_disp_grp_id;
    logic [RNID_W-1:0]            i_disp_rs2_rnid;
    logic                         i_disp_rs2_ready;
    logic [WAKE_NUM-1:0]          i_wake_valid;
    logic [WAKE_NUM*RNID_W-1:0]   i_wake_rnid;
    logic                         i_ex1_valid;
    logic                         i_ex1_hazard;
    logic [PADDR_W-1:0]           i_ex1_paddr;
    logic [DATA_W/8-1:0]          i_ex1_be;
    logic                         i_ex1_data_valid;
    logic [DATA_W-1:0]            i_ex1_data;
    logic                         i_st_data_valid;
    logic [DATA_W-1:0]            i_st_data;
    logic [LSU_INST_NUM-1:0]      i_tlb_resolve;
    logic                         i_rerun_accept;
    logic                         i_commit_valid;
    logic [CMT_ID_W-1:0]          i_commit_cmt_id;
    logic [GRP_W-1:0]             i_commit_grp_id;
    logic                         i_flush;
    logic                         i_sq_accept;
    logic                         i_sq_rd_miss;
    logic                         i_sq_rd_conflict;
    logic [LRQ_SIZE-1:0]          i_sq_lrq_index_oh;
    logic                         i_lrq_resolve_valid;
    logic [LRQ_SIZE-1:0]          i_lrq_resolve_oh;
    logic                         i_sq_wr_conflict;
    logic [LSU_INST_NUM-1:0]      i_fwd_valid;
    logic [LSU_INST_NUM*PADDR_W-1:0] i_fwd_paddr;

    logic                         o_valid;
    stq_state_t                   o_state;
    logic [PADDR_W-1:0]           o_paddr;
    logic [DATA_W/8-1:0]          o_be;
    logic [DATA_W-1:0]            o_data;
    logic [CMT_ID_W-1:0]          o_cmt_id;
    logic [GRP_W-1:0]             o_grp_id;
    logic                         o_rerun_req;
    logic                         o_commit_req;
    logic [LSU_INST_NUM-1:0]      o_fwd_hit;
    logic                         o_replay_ovf;

    modport master (
        output i_disp_load, i_disp_cmt_id, i_disp_grp_id, i_disp_rs2_rnid, i_disp_rs2_ready,
        output i_wake_valid, i_wake_rnid,
        output i_ex1_valid, i_ex1_hazard, i_ex1_paddr, i_ex1_be, i_ex1_data_valid, i_ex1_data,
        output i_st_data_valid, i_st_data, i_tlb_resolve, i_rerun_accept,
        output i_commit_valid, i_commit_cmt_id, i_commit_grp_id, i_flush,
        output i_sq_accept, i_sq_rd_miss, i_sq_rd_conflict, i_sq_lrq_index_oh,
        output i_lrq_resolve_valid, i_lrq_resolve_oh, i_sq_wr_conflict,
        output i_fwd_valid, i_fwd_paddr,
        input  o_valid, o_state, o_paddr, o_be, o_data, o_cmt_id, o_grp_id,
        input  o_rerun_req, o_commit_req, o_fwd_hit, o_replay_ovf
    );

    modport slave (
        input  i_disp_load, i_disp_cmt_id, i_disp_grp_id, i_disp_rs2_rnid, i_disp_rs2_ready,
        input  i_wake_valid, i_wake_rnid,
        input  i_ex1_valid, i_ex1_hazard, i_ex1_paddr, i_ex1_be, i_ex1_data_valid, i_ex1_data,
        input  i_st_data_valid, i_st_data, i_tlb_resolve, i_rerun_accept,
        input  i_commit_valid, i_commit_cmt_id, i_commit_grp_id, i_flush,
        input  i_sq_accept, i_sq_rd_miss, i_sq_rd_conflict, i_sq_lrq_index_oh,
        input  i_lrq_resolve_valid, i_lrq_resolve_oh, i_sq_wr_conflict,
        input  i_fwd_valid, i_fwd_paddr,
        output o_valid, o_state, o_paddr, o_be, o_data, o_cmt_id, o_grp_id,
        output o_rerun_req, o_commit_req, o_fwd_hit, o_replay_ovf
    );

endinterface

// File: rtl/msrh_stq_rs2_wake_sel.sv
// WAKE_NUM-way physical register id comparator for the store-data operand.
// Ports: i_wake_valid/i_wake_rnid - wakeup buses (rnid k at [k*RNID_W +: RNID_W]);
//        i_rs2_rnid - id the entry waits on; o_hit - any valid bus matches.
module msrh_stq_rs2_wake_sel #(
    parameter int WAKE_NUM = 4,
    parameter int RNID_W   = 7
) (
    input  logic [WAKE_NUM-1:0]        i_wake_valid,
    input  logic [WAKE_NUM*RNID_W-1:0] i_wake_rnid,
    input  logic [RNID_W-1:0]          i_rs2_rnid,
    output logic                       o_hit
);

    // OR-reduce the per-bus matches.
    always_comb begin
        o_hit = 1'b0;
        for (int k = 0; k < WAKE_NUM; k++) begin
            if (i_wake_valid[k] && (i_wake_rnid[k*RNID_W +: RNID_W] == i_rs2_rnid)) begin
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msrh_stq_entry_mp.sv
// One store-queue entry: tracks a store from dispatch through address/data
// capture, commit, L1D write and replay, and answers load-forwarding probes.
// Ports: i_clk, i_reset (synchronous, active-high); bus - slave side of
// msrh_stq_entry_mp_if carrying all event inputs and the entry view outputs.
module msrh_stq_entry_mp
    import msrh_lsu_pkg::*;
#(
    parameter int LSU_INST_NUM = 2,
    parameter int DATA_W       = 64,
    parameter int PADDR_W      = 56,
    parameter int RNID_W       = 7,
    parameter int WAKE_NUM     = 4,
    parameter int CMT_ID_W     = 6,
    parameter int GRP_W        = 4,
    parameter int LRQ_SIZE     = 8,
    parameter int MAX_REPLAY   = STQ_MAX_REPLAY
) (
    input  logic               i_clk,
    input  logic               i_reset,
    msrh_stq_entry_mp_if.slave bus
);

    localparam logic [STQ_REPLAY_W-1:0] MAX_CNT = STQ_REPLAY_W'(MAX_REPLAY);

    stq_state_t                state;
    logic                      valid;
    logic                      rs2_ready;
    logic                      got_data;
    logic                      replay_ovf;
    logic [CMT_ID_W-1:0]       cmt_id;
    logic [GRP_W-1:0]          grp_id;
    logic [RNID_W-1:0]         rs2_rnid;
    logic [PADDR_W-1:0]        paddr;
    logic [DATA_W/8-1:0]       be;
    logic [DATA_W-1:0]         data;
    logic [LRQ_SIZE-1:0]       lrq_oh;
    logic [STQ_REPLAY_W-1:0]   replay_cnt;
    logic [STQ_REPLAY_W-1:0]   replay_next;
    logic                      wake_hit;
    logic                      commit_match;
    logic                      flush_kill;

    msrh_stq_rs2_wake_sel #(
        .WAKE_NUM (WAKE_NUM),
        .RNID_W   (RNID_W)
    ) u_wake_sel (
        .i_wake_valid (bus.i_wake_valid),
        .i_wake_rnid  (bus.i_wake_rnid),
        .i_rs2_rnid   (rs2_rnid),
        .o_hit        (wake_hit)
    );

    // The committing instruction's own store survives a flush that it raises.
    assign commit_match = bus.i_commit_valid && (cmt_id == bus.i_commit_cmt_id) &&
                          (|(grp_id & bus.i_commit_grp_id));
    assign flush_kill   = bus.i_commit_valid && bus.i_flush &&
                          !((state == DONE) && commit_match);
    assign replay_next  = replay_sat_inc(replay_cnt, MAX_CNT);

    // Entry state machine; a flush overrides every other event.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= INIT;
            valid      <= 1'b0;
            rs2_ready  <= 1'b0;
            got_data   <= 1'b0;
            replay_ovf <= 1'b0;
            cmt_id     <= '0;
            grp_id     <= '0;
            rs2_rnid   <= '0;
            paddr      <= '0;
            be         <= '0;
            data       <= '0;
            lrq_oh     <= '0;
            replay_cnt <= '0;
        end else begin
            if (wake_hit) begin
                rs2_ready <= 1'b1;
            end
            if (flush_kill) begin
                valid  <= 1'b0;
                state  <= INIT;
                cmt_id <= '0;
                grp_id <= '0;
            end else begin
                case (state)
                    INIT: begin
                        if (bus.i_disp_load) begin
                            valid      <= 1'b1;
                            cmt_id     <= bus.i_disp_cmt_id;
                            grp_id     <= bus.i_disp_grp_id;
                            rs2_rnid   <= bus.i_disp_rs2_rnid;
                            rs2_ready  <= bus.i_disp_rs2_ready;
                            got_data   <= 1'b0;
                            be         <= '0;
                            replay_cnt <= '0;
                        end else if (valid && bus.i_ex1_valid) begin
                            paddr <= bus.i_ex1_paddr;
                            be    <= bus.i_ex1_be;
                            if (bus.i_ex1_hazard) begin
                                state <= TLB_HAZ;
                            end else if (bus.i_ex1_data_valid) begin
                                data     <= bus.i_ex1_data;
                                got_data <= 1'b1;
                                state    <= DONE;
                            end else begin
                                state <= WAIT_DATA;
                            end
                        end
                    end
                    TLB_HAZ: begin
                        if (|bus.i_tlb_resolve) state <= READY;
                    end
                    WAIT_DATA: begin
                        if (bus.i_st_data_valid) begin
                            data     <= bus.i_st_data;
                            got_data <= 1'b1;
                            state    <= DONE;
                        end else if (rs2_ready) begin
                            state <= READY;
                        end
                    end
                    READY: begin
                        if (bus.i_rerun_accept) state <= INIT;
                    end
                    DONE: begin
                        if (commit_match) state <= COMMIT;
                    end
                    COMMIT: begin
                        if (bus.i_sq_accept) state <= L1D_CHECK;
                    end
                    L1D_CHECK: begin
                        if (bus.i_sq_rd_miss) begin
                            lrq_oh <= bus.i_sq_lrq_index_oh;
                            state  <= WAIT_LRQ;
                        end else if (bus.i_sq_rd_conflict) begin
                            replay_cnt <= replay_next;
                            replay_ovf <= replay_ovf | (replay_next == MAX_CNT);
                            state      <= COMMIT;
                        end else begin
                            state <= L1D_UPDATE;
                        end
                    end
                    WAIT_LRQ: begin
                        // An empty LRQ index means the miss was already resolved.
                        if ((lrq_oh == '0) ||
                            (bus.i_lrq_resolve_valid && (bus.i_lrq_resolve_oh == lrq_oh))) begin
                            state <= COMMIT;
                        end
                    end
                    L1D_UPDATE: begin
                        if (bus.i_sq_wr_conflict) begin
                            replay_cnt <= replay_next;
                            replay_ovf <= replay_ovf | (replay_next == MAX_CNT);
                            state      <= COMMIT;
                        end else begin
                            valid <= 1'b0;
                            state <= INIT;
                        end
                    end
                    default: state <= INIT;
                endcase
            end
        end
    end

    assign bus.o_valid      = valid;
    assign bus.o_state      = state;
    assign bus.o_paddr      = paddr;
    assign bus.o_be         = be;
    assign bus.o_data       = data;
    assign bus.o_cmt_id     = cmt_id;
    assign bus.o_grp_id     = grp_id;
    assign bus.o_rerun_req  = (state == READY);
    assign bus.o_commit_req = (state == COMMIT);
    assign bus.o_replay_ovf = replay_ovf;

    // Forward hits compare at doubleword granularity and need captured data.
    for (genvar p = 0; p < LSU_INST_NUM; p++) begin : g_fwd
        assign bus.o_fwd_hit[p] = bus.i_fwd_valid[p] & valid & got_data & (|be) &
            (paddr[PADDR_W-1:STQ_FWD_LSB] ==
             bus.i_fwd_paddr[p*PADDR_W+STQ_FWD_LSB +: PADDR_W-STQ_FWD_LSB]);
    end

    // A dispatch may only reallocate an entry sitting in INIT.
    a_disp_only_in_init: assert property (@(posedge i_clk) disable iff (i_reset)
        !(bus.i_disp_load && (state != INIT)));

endmodule
